// File: rtl/mp_pipe_mem_if.sv
// Request/response bundle for mp_pipe_mem: per-port valid/ready request channel plus response strobe.
// Latency: none, this is wiring only. The request channel is valid/ready, and responses are never back-pressured.
// Backpressure: req_ready is driven by the memory arbiter. A requester must hold req_valid and its fields until ready.
//
// Ports (slave view, memory side):
//   req_valid  in   [NUM_PORTS]               request present
//   req_ready  out  [NUM_PORTS]               one-hot grant; transfer when valid & ready
//   req_we     in   [NUM_PORTS]               1 = write, 0 = read
//   req_size   in   [NUM_PORTS][1:0]          2'd0 = BYTE, 2'd2 = WORD, anything else is rejected
//   req_addr   in   [NUM_PORTS][ADDR_WIDTH]   byte address
//   req_wdata  in   [NUM_PORTS][DATA_WIDTH]   write data, little-endian
//   rsp_valid  out  [NUM_PORTS]               one-cycle response strobe to the originating port
//   rsp_err    out  [NUM_PORTS]               response carries an error
//   rsp_data   out  [NUM_PORTS][DATA_WIDTH]   read data (BYTE zero-extended), 0 when no response
//   debug_mem  out  [7:0] x MEM_SIZE          mirror of the array for simulation visibility
interface mp_pipe_mem_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 1024
);
    logic [NUM_PORTS-1:0]                 req_valid;
    logic [NUM_PORTS-1:0]                 req_ready;
    logic [NUM_PORTS-1:0]                 req_we;
    logic [NUM_PORTS-1:0][1:0]            req_size;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] req_addr;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] req_wdata;
    logic [NUM_PORTS-1:0]                 rsp_valid;
    logic [NUM_PORTS-1:0]                 rsp_err;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rsp_data;
    logic [7:0]                           debug_mem [MEM_SIZE];

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_err, rsp_data, debug_mem
    );

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_err, rsp_data, debug_mem
    );
endinterface

// File: rtl/mp_pipe_mem.sv
// Multi-port pipelined byte-addressed memory model with round-robin arbitration and error responses.
// Latency: a response appears LATENCY cycles after the accept cycle. The array is touched at ACCESS_STAGE.
// Backpressure: one request is accepted per cycle via a one-hot ready. Responses are never stalled.
//
// Ports:
//   clk_i  in  clock
//   rst_i  in  asynchronous active-high reset. It drops all in-flight requests but does not clear the array.
//   bus    mp_pipe_mem_if.slave  request/response channels for NUM_PORTS requesters
module mp_pipe_mem #(
    parameter int MEM_SIZE     = 1024,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_PORTS    = 2,
    parameter int LATENCY      = 10,
    parameter int ACCESS_STAGE = 5,
    parameter int ALIGN_CHECK  = 1,
    parameter     INIT_FILE    = ""
) (
    input  logic            clk_i,
    input  logic            rst_i,
    mp_pipe_mem_if.slave    bus
);
    localparam int IDXW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam int PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int AW1  = ADDR_WIDTH + 1;
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef struct packed {
        logic [PW-1:0]         id;
        logic                  we;
        logic [1:0]            size;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic                  err;
    } req_t;

    logic [7:0]            mem [MEM_SIZE];
    logic [PW-1:0]         rr_ptr;      // port with highest priority this cycle
    logic [NUM_PORTS-1:0]  grant;
    logic [PW-1:0]         grant_id;
    logic                  grant_any;
    logic [PW-1:0]         cand;
    req_t                  acc_req;
    logic [ADDR_WIDTH:0]   acc_end;

    req_t                  st      [1:LATENCY];
    logic [LATENCY:1]      st_vld;
    logic [DATA_WIDTH-1:0] st_data [1:LATENCY];

    req_t                  acc;
    logic [IDXW-1:0]       acc_idx;
    logic [DATA_WIDTH-1:0] rd_data;
    req_t                  out;
    logic                  out_vld;
    logic [DATA_WIDTH-1:0] out_data;

    // Round-robin search upward (wrapping) from rr_ptr. The first valid port wins.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = PW'((int'(rr_ptr) + i) % NUM_PORTS);
            if (!grant_any && bus.req_valid[cand]) begin
                grant_any   = 1'b1;
                grant_id    = cand;
                grant[cand] = 1'b1;
            end
        end
        if (rst_i) begin
            grant     = '0;
            grant_any = 1'b0;
        end
    end

    assign bus.req_ready = grant;

    // Capture the granted request and classify it once, at accept time.
    always_comb begin
        acc_req.id    = grant_id;
        acc_req.we    = bus.req_we[grant_id];
        acc_req.size  = bus.req_size[grant_id];
        acc_req.addr  = bus.req_addr[grant_id];
        acc_req.wdata = bus.req_wdata[grant_id];
        acc_end       = {1'b0, acc_req.addr} + ((acc_req.size == SZ_WORD) ? AW1'(4) : AW1'(1));
        acc_req.err   = ((acc_req.size != SZ_BYTE) && (acc_req.size != SZ_WORD))
                     || (acc_end > AW1'(MEM_SIZE))
                     || ((ALIGN_CHECK != 0) && (acc_req.size == SZ_WORD) && (acc_req.addr[1:0] != 2'b00));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_id == PW'(NUM_PORTS - 1)) ? '0 : grant_id + PW'(1);
        end
    end

    // Valid bits carry the reset. Payload is free-running and only meaningful where valid is set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_vld <= '0;
        end else begin
            st_vld[1] <= grant_any;
            for (int s = 2; s <= LATENCY; s++) begin
                st_vld[s] <= st_vld[s-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        st[1]      <= acc_req;
        st_data[1] <= '0;
        for (int s = 2; s <= LATENCY; s++) begin
            st[s]      <= st[s-1];
            st_data[s] <= (s - 1 == ACCESS_STAGE) ? rd_data : st_data[s-1];
        end
    end

    // Array access stage. The bounds check at accept guarantees addr..addr+3 fits in the index width.
    assign acc     = st[ACCESS_STAGE];
    assign acc_idx = acc.addr[IDXW-1:0];

    always_comb begin
        rd_data = '0;
        if (!acc.we && !acc.err) begin
            if (acc.size == SZ_WORD) begin
                rd_data = DATA_WIDTH'({mem[acc_idx + IDXW'(3)], mem[acc_idx + IDXW'(2)],
                                       mem[acc_idx + IDXW'(1)], mem[acc_idx]});
            end else begin
                rd_data = DATA_WIDTH'(mem[acc_idx]);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (st_vld[ACCESS_STAGE] && acc.we && !acc.err) begin
            mem[acc_idx] <= acc.wdata[7:0];
            if (acc.size == SZ_WORD) begin
                mem[acc_idx + IDXW'(1)] <= acc.wdata[15:8];
                mem[acc_idx + IDXW'(2)] <= acc.wdata[23:16];
                mem[acc_idx + IDXW'(3)] <= acc.wdata[31:24];
            end
        end
    end

    // Response: reads always answer. Writes answer only when rejected.
    assign out      = st[LATENCY];
    assign out_vld  = st_vld[LATENCY] && (!out.we || out.err);
    assign out_data = (ACCESS_STAGE == LATENCY) ? rd_data : st_data[LATENCY];

    always_comb begin
        bus.rsp_valid = '0;
        bus.rsp_err   = '0;
        bus.rsp_data  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (out_vld && (out.id == PW'(p))) begin
                bus.rsp_valid[p] = 1'b1;
                bus.rsp_err[p]   = out.err;
                bus.rsp_data[p]  = out.err ? '0 : out_data;
            end
        end
    end

    assign bus.debug_mem = mem;

endmodule

// File: tb/tb_mp_pipe_mem.sv
// Directed bench for mp_pipe_mem with a per-port scoreboard and an independent response monitor.
// Latency: expected responses are tagged with accept cycle + LAT and checked on the exact cycle.
// Backpressure: the driver holds valid until it sees ready. Every wait is bounded by a cycle budget.
module tb_mp_pipe_mem;
    localparam int LAT = 10;
    localparam int MS  = 1024;
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef struct {
        int          cyc;
        bit          err;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   no_push = 1'b0;
    exp_t sb0[$];
    exp_t sb1[$];

    mp_pipe_mem_if #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(MS)) bus ();

    mp_pipe_mem #(
        .MEM_SIZE(MS), .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_PORTS(2),
        .LATENCY(LAT), .ACCESS_STAGE(5), .ALIGN_CHECK(1), .INIT_FILE("")
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_exp(input int p, input int c, input bit e, input logic [31:0] d);
        exp_t x;
        x.cyc  = c + LAT;
        x.err  = e;
        x.data = d;
        if (p == 0) sb0.push_back(x);
        else        sb1.push_back(x);
    endtask

    // Monitor: every negedge, each port either presents a response that must match the head of its queue,
    // or it must show zero err/data.
    always @(negedge clk) begin : mon
        exp_t x;
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (bus.rsp_valid[p]) begin
                if ((p == 0 && sb0.size() == 0) || (p == 1 && sb1.size() == 0)) begin
                    errors++;
                    $display("FAIL rsp_unexpected port %0d cyc %0d: got data %h err %b, required no response",
                             p, cyc, bus.rsp_data[p], bus.rsp_err[p]);
                end else begin
                    if (p == 0) x = sb0.pop_front();
                    else        x = sb1.pop_front();
                    if (x.cyc != cyc || x.err !== bus.rsp_err[p] || x.data !== bus.rsp_data[p]) begin
                        errors++;
                        $display("FAIL rsp_match port %0d: got cyc %0d data %h err %b, required cyc %0d data %h err %b",
                                 p, cyc, bus.rsp_data[p], bus.rsp_err[p], x.cyc, x.data, x.err);
                    end
                end
            end else if (bus.rsp_err[p] !== 1'b0 || bus.rsp_data[p] !== 32'h0) begin
                errors++;
                $display("FAIL rsp_idle port %0d cyc %0d: got data %h err %b, required 0",
                         p, cyc, bus.rsp_data[p], bus.rsp_err[p]);
            end
        end
    end

    // Present one request on port p, wait for the grant, and record the expected response.
    task automatic do_req(input int p, input bit we, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input bit ee, input logic [31:0] ed);
        int n = 0;
        bus.req_valid[p] = 1'b1;
        bus.req_we[p]    = we;
        bus.req_size[p]  = sz;
        bus.req_addr[p]  = a;
        bus.req_wdata[p] = wd;
        forever begin
            @(negedge clk);
            if (bus.req_ready[p]) break;
            n++;
            if (n > 20) break;
        end
        checks++;
        if (!bus.req_ready[p] || $countones(bus.req_ready) != 1) begin
            errors++;
            $display("FAIL grant port %0d addr %h: got ready %b, required one-hot grant to this port",
                     p, a, bus.req_ready);
        end else if ((!we || ee) && !no_push) begin
            push_exp(p, cyc, ee, ed);
        end
        @(posedge clk);
        #1;
        bus.req_valid[p] = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
            if (sb0.size() == 0 && sb1.size() == 0) break;
            @(posedge clk);
        end
        @(posedge clk);
        #1;
        checks++;
        if (sb0.size() != 0 || sb1.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d responses outstanding, required 0/0", sb0.size(), sb1.size());
            sb0.delete();
            sb1.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin : stim
        int exp_g [4];
        int rem   [2];
        int g;

        // 1: reset held with both ports requesting -> no grants
        rst           = 1'b1;
        bus.req_valid = 2'b11;
        bus.req_we    = 2'b00;
        bus.req_size  = {SZ_WORD, SZ_WORD};
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.req_ready !== 2'b00) begin
                errors++;
                $display("FAIL ready_in_reset: got %b, required 00", bus.req_ready);
            end
        end
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.req_valid = 2'b00;

        do_req(1, 1'b1, SZ_WORD, 32'h40, 32'hDEADBEEF, 1'b0, 32'h0);
        do_req(0, 1'b1, SZ_WORD, 32'h80, 32'h12345678, 1'b0, 32'h0);

        // 2: read back on port 1 with exact latency
        do_req(1, 1'b0, SZ_WORD, 32'h40, 32'h0, 1'b0, 32'hDEADBEEF);

        // 3: both ports valid; last grant was port 1, so grants go 0,1,0,1
        exp_g = '{0, 1, 0, 1};
        rem   = '{2, 2};
        bus.req_we    = 2'b00;
        bus.req_size  = {SZ_WORD, SZ_WORD};
        bus.req_addr  = {32'h40, 32'h80};
        bus.req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.req_ready !== (2'b01 << exp_g[i])) begin
                errors++;
                $display("FAIL grant_rr step %0d: got ready %b, required port %0d", i, bus.req_ready, exp_g[i]);
            end
            g = -1;
            if (bus.req_ready == 2'b01) begin
                push_exp(0, cyc, 1'b0, 32'h12345678);
                g = 0;
            end else if (bus.req_ready == 2'b10) begin
                push_exp(1, cyc, 1'b0, 32'hDEADBEEF);
                g = 1;
            end
            @(posedge clk);
            #1;
            if (g >= 0) begin
                rem[g]--;
                if (rem[g] == 0) bus.req_valid[g] = 1'b0;
            end
        end
        bus.req_valid = 2'b00;

        // 4: byte write then word read on the very next cycle sees the new byte
        do_req(1, 1'b1, SZ_BYTE, 32'h41, 32'h000000AA, 1'b0, 32'h0);
        do_req(1, 1'b0, SZ_WORD, 32'h40, 32'h0, 1'b0, 32'hDEADAAEF);
        do_req(0, 1'b0, SZ_BYTE, 32'h43, 32'h0, 1'b0, 32'h000000DE);

        // 5: errors (misaligned, out of range, bad size, errored write) and top-of-array boundary
        do_req(1, 1'b0, SZ_WORD, 32'h42, 32'h0, 1'b1, 32'h0);
        do_req(1, 1'b0, SZ_WORD, MS - 2, 32'h0, 1'b1, 32'h0);
        do_req(0, 1'b1, SZ_WORD, 32'h41, 32'hFFFFFFFF, 1'b1, 32'h0);
        do_req(0, 1'b0, SZ_HALF, 32'h40, 32'h0, 1'b1, 32'h0);
        do_req(0, 1'b0, SZ_BYTE, MS, 32'h0, 1'b1, 32'h0);
        do_req(1, 1'b1, SZ_WORD, MS - 4, 32'hCAFEF00D, 1'b0, 32'h0);
        do_req(0, 1'b1, SZ_BYTE, MS - 1, 32'h0000005A, 1'b0, 32'h0);
        do_req(1, 1'b0, SZ_WORD, MS - 4, 32'h0, 1'b0, 32'h5AFEF00D);
        do_req(0, 1'b0, SZ_BYTE, MS - 1, 32'h0, 1'b0, 32'h0000005A);
        do_req(1, 1'b0, SZ_WORD, 32'h40, 32'h0, 1'b0, 32'hDEADAAEF);
        wait_drain();
        checks++;
        if (bus.debug_mem[32'h41] !== 8'hAA) begin
            errors++;
            $display("FAIL debug_mem[0x41]: got %h, required aa", bus.debug_mem[32'h41]);
        end

        // 6: reset with a write and two reads in flight -> nothing comes back, the write is lost
        no_push = 1'b1;
        do_req(0, 1'b1, SZ_WORD, 32'h40, 32'h11111111, 1'b0, 32'h0);
        do_req(1, 1'b0, SZ_WORD, 32'h40, 32'h0, 1'b0, 32'h0);
        do_req(0, 1'b0, SZ_BYTE, MS - 1, 32'h0, 1'b0, 32'h0);
        no_push = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (LAT + 4) @(posedge clk);
        #1;
        do_req(1, 1'b0, SZ_WORD, 32'h40, 32'h0, 1'b0, 32'hDEADAAEF);
        do_req(0, 1'b0, SZ_BYTE, MS - 1, 32'h0, 1'b0, 32'h0000005A);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
